mult_div_unit: RTL
==================

Name: mult_div_unit

Overview:
- Iterative multiply/divide unit with architectural HI/LO registers for the multi-cycle MIPS core.
- Sits downstream of the A/B operand registers: it consumes the latched rs/rt values and produces HI/LO for MFHI/MFLO write-back.
- The control FSM starts an operation, holds its own state while busy is high, and continues on done.
- Covers MULT, MULTU, DIV, DIVU, MTHI and MTLO.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request an operation; sampled only in IDLE.
- op  input  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- a  input  WIDTH  rs operand (multiplicand / dividend).
- b  input  WIDTH  rt operand (multiplier / divisor).
- hi_we  input  1  MTHI write enable.
- lo_we  input  1  MTLO write enable.
- wdata  input  WIDTH  MTHI/MTLO data.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse; HI/LO already hold the new result.
- div_zero  output  1  sticky flag: last divide had b==0; cleared by the next start.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- One clock, clk. Reset is synchronous and active-high (rst), sampled on the rising edge of clk.
- Reset values: state=IDLE, busy=0, done=0, div_zero=0, hi=0, lo=0, counter=0.
- Reset mid-operation aborts immediately. HI/LO are zeroed and no done pulse is produced.
- States:
  - IDLE -> CALC: on start=1. At the same edge, capture |a| and |b| (magnitudes only for signed ops), the result signs, op, and counter=0. Set busy=1, div_zero=0, done=0.
  - CALC: one radix-2 step per cycle. Multiply is shift-add over a 2*WIDTH product register. Divide is restoring shift-subtract producing one quotient bit per cycle. Counter increments each step; after WIDTH steps -> SIGN.
  - SIGN: one cycle. Apply sign correction, write HI/LO, set done=1, busy=0, then -> IDLE.
- Latency: start sampled at edge E0; CALC covers E1..E32; HI/LO written and done set at E33. busy is high for exactly 33 cycles. done is high for exactly one cycle after E33.
- Multiply results:
  - {hi,lo} = full 64-bit product.
  - MULT negates the 64-bit magnitude product when sign(a) xor sign(b).
- Divide results:
  - lo = quotient, hi = remainder.
  - Signed division truncates toward zero; the remainder takes the sign of the dividend.
- Divide by zero (b==0, DIVU or DIV):
  - Iteration still runs the full 33 cycles.
  - Result is lo=0xFFFFFFFF, hi=a unchanged, div_zero=1.
- Signed overflow (DIV, a=0x80000000, b=0xFFFFFFFF): lo=0x80000000, hi=0, div_zero=0.
- Start handling:
  - start while busy is ignored; operands and op are not re-captured.
  - start in the same cycle as done (SIGN state) is ignored; the controller must wait for IDLE.
- MTHI/MTLO writes:
  - hi_we/lo_we in IDLE write wdata at the edge.
  - hi_we/lo_we while busy or in SIGN are dropped.
  - start and hi_we/lo_we together in IDLE: start wins and the write is dropped.
- hi/lo are stable and readable at all times except at the SIGN edge. During CALC they retain their previous values.

Test Plan:
- rst=1 for 2 cycles after arbitrary MTHI/MTLO writes -> hi=lo=0, busy=0, done=0, div_zero=0.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> done at cycle 33 after start, hi=0xFFFFFFFE, lo=0x00000001; busy high exactly 33 cycles.
- MULT a=0xFFFFFFFD (-3), b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU a=100, b=0 -> lo=0xFFFFFFFF, hi=0x00000064, div_zero=1. The next MULTU 2*3 -> div_zero cleared at start, hi=0, lo=6.
- DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0. Pulse start again with a=1 at cycle 5 while busy -> ignored, result unchanged.
- Start MULTU 5*5, assert rst at cycle 10 -> hi=lo=0, busy=0, no done pulse. Then MTLO wdata=0x1234 in IDLE -> lo=0x1234. lo_we during a following busy period -> lo unchanged until done.

Source files
------------

// File: rtl/mult_div_unit.sv
// Iterative MIPS HI/LO multiply/divide unit: radix-2 shift-add multiply, restoring divide.
// Latency 33 cycles start-to-done; start is ignored while busy, MTHI/MTLO only land when idle.
module mult_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_SIGN = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [2*WIDTH-1:0]     acc_q, acc_d;
    logic [WIDTH-1:0]       opb_q, opb_d;
    logic [WIDTH-1:0]       hi_q, hi_d;
    logic [WIDTH-1:0]       lo_q, lo_d;
    logic                   is_div_q, is_div_d;
    logic                   neg_q, neg_d;
    logic                   rneg_q, rneg_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   dz_q, dz_d;

    logic                   a_neg, b_neg;
    logic [WIDTH-1:0]       a_mag, b_mag;
    logic [WIDTH:0]         mul_sum;
    logic [WIDTH:0]         div_shift, div_sub;
    logic                   div_ge;
    logic [WIDTH-1:0]       div_rem;
    logic [2*WIDTH-1:0]     prod_fix;
    logic [WIDTH-1:0]       quot_fix, rem_fix;

    // Signed ops run on magnitudes; signs are re-applied in the SIGN cycle.
    assign a_neg = op[0] & a[WIDTH-1];
    assign b_neg = op[0] & b[WIDTH-1];
    assign a_mag = a_neg ? (~a + WIDTH'(1)) : a;
    assign b_mag = b_neg ? (~b + WIDTH'(1)) : b;

    // acc holds {partial product, multiplier} or {remainder, dividend/quotient}.
    assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                       {1'b0, (acc_q[0] ? opb_q : {WIDTH{1'b0}})};
    assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign div_sub   = div_shift - {1'b0, opb_q};
    assign div_ge    = (div_shift >= {1'b0, opb_q});
    assign div_rem   = WIDTH'(div_ge ? div_sub : div_shift);

    assign prod_fix = neg_q  ? (~acc_q + (2*WIDTH)'(1)) : acc_q;
    assign quot_fix = neg_q  ? (~acc_q[WIDTH-1:0] + WIDTH'(1)) : acc_q[WIDTH-1:0];
    assign rem_fix  = rneg_q ? (~acc_q[2*WIDTH-1:WIDTH] + WIDTH'(1)) : acc_q[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opb_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opb_q    <= opb_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            is_div_q <= is_div_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            dz_q     <= dz_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_CALC;
            S_CALC:  if (cnt_q == CNT_W'(WIDTH-1)) state_d = S_SIGN;
            S_SIGN:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opb_d    = opb_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        is_div_d = is_div_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        dz_d     = dz_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    acc_d    = {{WIDTH{1'b0}}, (op[1] ? a_mag : b_mag)};
                    opb_d    = op[1] ? b_mag : a_mag;
                    is_div_d = op[1];
                    neg_d    = a_neg ^ b_neg;
                    rneg_d   = a_neg;
                    cnt_d    = '0;
                    busy_d   = 1'b1;
                    dz_d     = 1'b0;
                end else begin
                    if (hi_we) hi_d = wdata;
                    if (lo_we) lo_d = wdata;
                end
            end
            S_CALC: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (is_div_q) acc_d = {div_rem, acc_q[WIDTH-2:0], div_ge};
                else          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
            end
            S_SIGN: begin
                busy_d = 1'b0;
                done_d = 1'b1;
                if (is_div_q) begin
                    // A zero divisor leaves the dividend magnitude as remainder, so hi returns a.
                    hi_d = rem_fix;
                    if (opb_q == '0) begin
                        lo_d = {WIDTH{1'b1}};
                        dz_d = 1'b1;
                    end else begin
                        lo_d = quot_fix;
                    end
                end else begin
                    {hi_d, lo_d} = prod_fix;
                end
            end
            default: ;
        endcase
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign div_zero = dz_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule
